ahb_slave_mem: RTL and testbench
================================

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 Parameter AddresseWidth, default 32: width of HADDR.
REQ-002 Parameter DataWidth, default 32: width of HWDATA and HRDATA.
REQ-003 Parameter Depth, default 16: number of DataWidth-bit words held; power of two, 2..256.
REQ-004 Parameter WaitStates, default 0: HREADY-low cycles inserted in every OKAY data phase, 0..15.
REQ-005 HCLK  input  1  bus clock; all state changes on rising edge.
REQ-006 HRESETn  input  1  asynchronous active-low reset.
REQ-007 HSEL  input  1  slave select from decoder.
REQ-008 HADDR  input  AddresseWidth  byte address, address phase.
REQ-009 HWRITE  input  1  1 = write, 0 = read, address phase.
REQ-010 HSIZE  input  3  transfer size (000 byte, 001 halfword, 010 word).
REQ-011 HBURST  input  3  burst type; accepted and otherwise ignored.
REQ-012 HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-013 HWDATA  input  DataWidth  write data, data phase.
REQ-014 HREADY  output  1  1 = data phase completes this cycle.
REQ-015 HRESP  output  1  0 = OKAY, 1 = ERROR.
REQ-016 HRDATA  output  DataWidth  read data, valid when HREADY=1 in a read data phase.

Function
REQ-017 A transfer SHALL be accepted on a rising edge where HSEL=1, HTRANS in {NONSEQ, SEQ} and HREADY=1; HADDR, HWRITE, HSIZE are then registered for the data phase.
REQ-018 IDLE or BUSY, or HSEL=0, SHALL cause no access and, if no data phase is pending, HREADY=1, HRESP=0.
REQ-019 State machine SHALL have states IDLE, WAIT, ERR1, ERR2.
REQ-020 IDLE: accepted valid transfer -> WAIT if WaitStates>0, else data phase completes next cycle with HREADY=1 while staying in IDLE; accepted illegal transfer -> ERR1.
REQ-021 WAIT: HREADY=0 for exactly WaitStates cycles (down-counter), then one HREADY=1 cycle completing the data phase.
REQ-022 Illegal transfer: HADDR >= 4*Depth, HSIZE > 010, halfword with HADDR[0]=1, or word with HADDR[1:0]!=00.
REQ-023 ERR1: HREADY=0, HRESP=1, one cycle -> ERR2; ERR2: HREADY=1, HRESP=1, one cycle -> IDLE (or next transfer); no wait states on errors.
REQ-024 An erroring transfer SHALL NOT modify memory; HRDATA SHALL be 0 in ERR1/ERR2.
REQ-025 Word index SHALL be registered HADDR[log2(Depth)+1:2].
REQ-026 Write SHALL commit on the edge ending the data phase (HREADY=1), only byte lanes selected: byte -> lane HADDR[1:0], halfword -> lanes {HADDR[1],0} and {HADDR[1],1}, word -> all four.
REQ-027 Read SHALL drive HRDATA = full stored word (all lanes) during the read data phase; HRDATA=0 at all other times.
REQ-028 Pipelining: a new address phase accepted in the same cycle a data phase completes SHALL start its data phase immediately next cycle, no bubble.
REQ-029 Write to word A followed directly by a pipelined read of A SHALL return the newly written value.
REQ-030 Address phases presented while HREADY=0 SHALL be ignored (master holds them).

Reset
REQ-031 HRESETn=0 SHALL immediately force: state IDLE, wait counter 0, HREADY=1, HRESP=0, HRDATA=0, all memory words 0.
REQ-032 Reset asserted mid data phase SHALL abort it; a pending write SHALL NOT be committed.
REQ-033 First transfer SHALL be accepted on the first rising edge after HRESETn deasserts.

Verification
REQ-034 WaitStates=0: NONSEQ write word 0x0000_0008 data 0xDEADBEEF, then pipelined NONSEQ read 0x08 -> HREADY never low, HRDATA=0xDEADBEEF, HRESP=0.
REQ-035 WaitStates=2: read 0x04 after reset -> HREADY low exactly 2 cycles, then HREADY=1, HRDATA=0x00000000.
REQ-036 Byte write 0xAB to 0x0000_0005 over word 0x11223344 at 0x04 -> readback 0x1122AB44.
REQ-037 Depth=16: write 0x0000_0040 -> HREADY=0/HRESP=1 then HREADY=1/HRESP=1, memory unchanged; halfword at 0x01 -> same ERROR.
REQ-038 INCR burst NONSEQ 0x00 then SEQ 0x04, 0x08, 0x0C with a BUSY beat between -> four writes committed in order, BUSY beat OKAY with no access.
REQ-039 HRESETn pulsed low during WAIT of write to 0x10 -> HREADY=1, HRDATA=0 at once, later read 0x10 returns 0.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// ---------------------------------------------------------------------------
// ahb_slave_mem
// AHB-Lite slave backed by a small register-file memory of Depth words.
// Supports byte/halfword/word transfers with byte-lane write strobes, an
// optional fixed number of wait states per OKAY transfer, and a two-cycle
// ERROR response for out-of-range or misaligned transfers.
//
// Ports:
//   HCLK, HRESETn      bus clock, asynchronous active-low reset
//   HSEL               slave select from the address decoder
//   HADDR/HWRITE/HSIZE address-phase controls (registered on acceptance)
//   HBURST             burst type, accepted but not used
//   HTRANS             IDLE / BUSY / NONSEQ / SEQ
//   HWDATA             write data, sampled in the data phase
//   HREADY/HRESP       registered transfer response
//   HRDATA             registered read data, zero outside read completion
// ---------------------------------------------------------------------------
module ahb_slave_mem #(
    parameter int AddresseWidth = 32,
    parameter int DataWidth     = 32,
    parameter int Depth         = 16,
    parameter int WaitStates    = 0
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     HSEL,
    input  logic [AddresseWidth-1:0] HADDR,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [2:0]               HBURST,
    input  logic [1:0]               HTRANS,
    input  logic [DataWidth-1:0]     HWDATA,
    output logic                     HREADY,
    output logic                     HRESP,
    output logic [DataWidth-1:0]     HRDATA
);

    localparam int IdxW  = $clog2(Depth);
    localparam int Lanes = DataWidth / 8;
    localparam logic [AddresseWidth-1:0] AddrLimit = AddresseWidth'(4 * Depth);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } state_t;

    // Byte-lane enables for a legal transfer of the given size and offset.
    function automatic logic [Lanes-1:0] lane_mask(input logic [2:0] size,
                                                   input logic [1:0] offs);
        logic [Lanes-1:0] m;
        case (size)
            3'b000:  m = Lanes'(4'b0001 << offs);
            3'b001:  m = offs[1] ? Lanes'(4'b1100) : Lanes'(4'b0011);
            default: m = '1;
        endcase
        return m;
    endfunction

    // Out-of-range, oversize or misaligned transfers get an ERROR response.
    function automatic logic is_illegal(input logic [AddresseWidth-1:0] addr,
                                        input logic [2:0]               size);
        logic bad;
        if (addr >= AddrLimit) begin
            bad = 1'b1;
        end else if (size > 3'b010) begin
            bad = 1'b1;
        end else if ((size == 3'b001) && addr[0]) begin
            bad = 1'b1;
        end else if ((size == 3'b010) && (addr[1:0] != 2'b00)) begin
            bad = 1'b1;
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

    state_t               state_r;
    logic [3:0]           cnt_r;
    logic                 hready_r;
    logic                 hresp_r;
    logic [DataWidth-1:0] hrdata_r;
    logic                 dp_valid_r;
    logic                 dp_write_r;
    logic [IdxW-1:0]      dp_idx_r;
    logic [Lanes-1:0]     dp_mask_r;
    logic [DataWidth-1:0] mem_r [Depth];

    logic                 accept_s;
    logic                 illegal_s;
    logic                 commit_s;
    logic [IdxW-1:0]      acc_idx_s;
    logic [DataWidth-1:0] merged_s;
    logic [DataWidth-1:0] acc_word_s;
    logic                 unused_s;

    assign accept_s  = HSEL && HTRANS[1] && hready_r;
    assign illegal_s = is_illegal(HADDR, HSIZE);
    // A write commits on the edge that ends its data phase (HREADY high).
    assign commit_s  = dp_valid_r && hready_r && dp_write_r;
    assign acc_idx_s = HADDR[IdxW+1:2];
    assign unused_s  = ^{HBURST, HTRANS[0]};

    // Stored word of the pending write merged with the active HWDATA lanes.
    always_comb begin
        merged_s = mem_r[dp_idx_r];
        for (int i = 0; i < Lanes; i++) begin
            if (dp_mask_r[i]) begin
                merged_s[8*i +: 8] = HWDATA[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = mem_r[dp_idx_r][8*i +: 8];
            end
        end
    end

    // Read word for a newly accepted address, forwarding a write committing now.
    always_comb begin
        if (commit_s && (dp_idx_r == acc_idx_s)) begin
            acc_word_s = merged_s;
        end else begin
            acc_word_s = mem_r[acc_idx_s];
        end
    end

    // Transfer state machine with registered bus response.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            hready_r   <= 1'b1;
            hresp_r    <= 1'b0;
            hrdata_r   <= '0;
            dp_valid_r <= 1'b0;
            dp_write_r <= 1'b0;
            dp_idx_r   <= '0;
            dp_mask_r  <= '0;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    hresp_r <= 1'b0;
                    if (cnt_r <= 4'd1) begin
                        // Last wait cycle: next cycle completes the data phase.
                        state_r  <= ST_IDLE;
                        cnt_r    <= 4'd0;
                        hready_r <= 1'b1;
                        hrdata_r <= dp_write_r ? '0 : mem_r[dp_idx_r];
                    end else begin
                        cnt_r    <= cnt_r - 4'd1;
                        hready_r <= 1'b0;
                        hrdata_r <= '0;
                    end
                end
                ST_ERR1: begin
                    state_r    <= ST_ERR2;
                    hready_r   <= 1'b1;
                    hresp_r    <= 1'b1;
                    hrdata_r   <= '0;
                    dp_valid_r <= 1'b0;
                end
                ST_IDLE, ST_ERR2: begin
                    if (accept_s && illegal_s) begin
                        state_r    <= ST_ERR1;
                        hready_r   <= 1'b0;
                        hresp_r    <= 1'b1;
                        hrdata_r   <= '0;
                        dp_valid_r <= 1'b0;
                    end else if (accept_s) begin
                        dp_valid_r <= 1'b1;
                        dp_write_r <= HWRITE;
                        dp_idx_r   <= acc_idx_s;
                        dp_mask_r  <= lane_mask(HSIZE, HADDR[1:0]);
                        hresp_r    <= 1'b0;
                        if (WaitStates > 0) begin
                            state_r  <= ST_WAIT;
                            cnt_r    <= 4'(WaitStates);
                            hready_r <= 1'b0;
                            hrdata_r <= '0;
                        end else begin
                            state_r  <= ST_IDLE;
                            hready_r <= 1'b1;
                            hrdata_r <= HWRITE ? '0 : acc_word_s;
                        end
                    end else begin
                        state_r    <= ST_IDLE;
                        hready_r   <= 1'b1;
                        hresp_r    <= 1'b0;
                        hrdata_r   <= '0;
                        dp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= 4'd0;
                    hready_r   <= 1'b1;
                    hresp_r    <= 1'b0;
                    hrdata_r   <= '0;
                    dp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Memory array; reset clears every word, writes commit lane-wise.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < Depth; i++) begin
                mem_r[i] <= '0;
            end
        end else if (commit_s) begin
            mem_r[dp_idx_r] <= merged_s;
        end
    end

    assign HREADY = hready_r;
    assign HRESP  = hresp_r;
    assign HRDATA = hrdata_r;

endmodule

// File: tb/tb_ahb_slave_mem.sv
module tb_ahb_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel0, hsel2;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hready0, hresp0, hready2, hresp2;
    logic [31:0] hrdata0, hrdata2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ahb_slave_mem #(.AddresseWidth(32), .DataWidth(32), .Depth(16), .WaitStates(0)) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
        .HREADY(hready0), .HRESP(hresp0), .HRDATA(hrdata0)
    );

    ahb_slave_mem #(.AddresseWidth(32), .DataWidth(32), .Depth(16), .WaitStates(2)) dut2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel2), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
        .HREADY(hready2), .HRESP(hresp2), .HRDATA(hrdata2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Single non-pipelined transfer; called at a negedge with the bus idle.
    task automatic xfer(input int which, input bit wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wd,
                        output logic [31:0] rd, output int low, output bit err);
        logic rdy;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        htrans = 2'b10;
        hsel0  = (which == 0);
        hsel2  = (which != 0);
        @(negedge clk);
        htrans = 2'b00;
        hsel0  = 1'b0;
        hsel2  = 1'b0;
        hwdata = wd;
        low    = 0;
        err    = 1'b0;
        rdy    = (which == 0) ? hready0 : hready2;
        while (!rdy && low < 20) begin
            low++;
            err = err | ((which == 0) ? hresp0 : hresp2);
            @(negedge clk);
            rdy = (which == 0) ? hready0 : hready2;
        end
        if (low >= 20) check("xfer_timeout", 32'(low), 32'd0);
        rd  = (which == 0) ? hrdata0 : hrdata2;
        err = err | ((which == 0) ? hresp0 : hresp2);
        @(negedge clk);
        hwdata = 32'h0;
    endtask

    logic [31:0] rd;
    int          low;
    bit          err;

    initial begin
        rst_n = 1'b0; hsel0 = 1'b0; hsel2 = 1'b0; haddr = 32'h0; hwrite = 1'b0;
        hsize = 3'b010; hburst = 3'b000; htrans = 2'b00; hwdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_hready0", {31'd0, hready0}, 32'd1);
        check("rst_hresp0",  {31'd0, hresp0},  32'd0);
        check("rst_hrdata0", hrdata0, 32'h0);
        check("rst_hready2", {31'd0, hready2}, 32'd1);
        check("rst_hrdata2", hrdata2, 32'h0);
        rst_n = 1'b1;

        // Pipelined write then read of the same word, no wait states.
        hsel0 = 1'b1; haddr = 32'h8; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
        @(negedge clk);
        check("pipe_wr_ready", {31'd0, hready0}, 32'd1);
        haddr = 32'h8; hwrite = 1'b0; htrans = 2'b10; hwdata = 32'hDEADBEEF;
        @(negedge clk);
        check("pipe_rd_ready", {31'd0, hready0}, 32'd1);
        check("pipe_rd_data",  hrdata0, 32'hDEADBEEF);
        check("pipe_rd_resp",  {31'd0, hresp0}, 32'd0);
        hsel0 = 1'b0; htrans = 2'b00; hwdata = 32'h0;
        @(negedge clk);
        check("pipe_rd_zero_after", hrdata0, 32'h0);

        // Byte and halfword lane writes.
        xfer(0, 1'b1, 32'h4, 3'b010, 32'h11223344, rd, low, err);
        xfer(0, 1'b1, 32'h5, 3'b000, 32'h0000AB00, rd, low, err);
        check("byte_wr_resp", {31'd0, err}, 32'd0);
        xfer(0, 1'b0, 32'h4, 3'b010, 32'h0, rd, low, err);
        check("byte_rd", rd, 32'h1122AB44);
        check("byte_rd_nowait", 32'(low), 32'd0);
        xfer(0, 1'b1, 32'h6, 3'b001, 32'hBEEF0000, rd, low, err);
        xfer(0, 1'b0, 32'h4, 3'b010, 32'h0, rd, low, err);
        check("half_rd", rd, 32'hBEEFAB44);

        // INCR burst with a BUSY beat; HWDATA during the BUSY gap is junk.
        hsel0 = 1'b1; hwrite = 1'b1; hsize = 3'b010; hburst = 3'b011;
        haddr = 32'h0; htrans = 2'b10;
        @(negedge clk);
        haddr = 32'h4; htrans = 2'b11; hwdata = 32'hA0A0A0A0;
        @(negedge clk);
        haddr = 32'h8; htrans = 2'b01; hwdata = 32'hA1A1A1A1;
        @(negedge clk);
        check("busy_ready", {31'd0, hready0}, 32'd1);
        check("busy_resp",  {31'd0, hresp0},  32'd0);
        haddr = 32'h8; htrans = 2'b11; hwdata = 32'hFFFFFFFF;
        @(negedge clk);
        haddr = 32'hC; htrans = 2'b11; hwdata = 32'hA2A2A2A2;
        @(negedge clk);
        hsel0 = 1'b0; htrans = 2'b00; hwdata = 32'hA3A3A3A3; hburst = 3'b000;
        @(negedge clk);
        hwdata = 32'h0;
        xfer(0, 1'b0, 32'h0, 3'b010, 32'h0, rd, low, err); check("burst_0", rd, 32'hA0A0A0A0);
        xfer(0, 1'b0, 32'h4, 3'b010, 32'h0, rd, low, err); check("burst_4", rd, 32'hA1A1A1A1);
        xfer(0, 1'b0, 32'h8, 3'b010, 32'h0, rd, low, err); check("burst_8", rd, 32'hA2A2A2A2);
        xfer(0, 1'b0, 32'hC, 3'b010, 32'h0, rd, low, err); check("burst_c", rd, 32'hA3A3A3A3);

        // Error responses; 0x40 would alias word 0 if it were not blocked.
        xfer(0, 1'b1, 32'h40, 3'b010, 32'h55555555, rd, low, err);
        check("oob_low",  32'(low), 32'd1);
        check("oob_resp", {31'd0, err}, 32'd1);
        check("oob_data", rd, 32'h0);
        xfer(0, 1'b1, 32'h1, 3'b001, 32'h66660000, rd, low, err);
        check("half_mis_resp", {31'd0, err}, 32'd1);
        xfer(0, 1'b1, 32'h2, 3'b010, 32'h77777777, rd, low, err);
        check("word_mis_resp", {31'd0, err}, 32'd1);
        xfer(0, 1'b1, 32'h0, 3'b011, 32'h88888888, rd, low, err);
        check("size_resp", {31'd0, err}, 32'd1);
        xfer(0, 1'b0, 32'h0, 3'b010, 32'h0, rd, low, err);
        check("err_mem_kept", rd, 32'hA0A0A0A0);
        check("ok_after_err", {31'd0, err}, 32'd0);
        xfer(0, 1'b1, 32'h3F, 3'b000, 32'h77000000, rd, low, err);
        check("last_byte_resp", {31'd0, err}, 32'd0);
        xfer(0, 1'b0, 32'h3C, 3'b010, 32'h0, rd, low, err);
        check("last_word", rd, 32'h77000000);

        // Two wait states.
        xfer(2, 1'b0, 32'h4, 3'b010, 32'h0, rd, low, err);
        check("ws_rd_low",  32'(low), 32'd2);
        check("ws_rd_data", rd, 32'h0);
        check("ws_rd_resp", {31'd0, err}, 32'd0);
        xfer(2, 1'b1, 32'hC, 3'b010, 32'hCAFEF00D, rd, low, err);
        check("ws_wr_low", 32'(low), 32'd2);
        xfer(2, 1'b0, 32'hC, 3'b010, 32'h0, rd, low, err);
        check("ws_rd_back", rd, 32'hCAFEF00D);

        // Reset asserted in the middle of a wait-stated write.
        hsel2 = 1'b1; haddr = 32'h10; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
        @(negedge clk);
        hsel2 = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
        check("abort_wait", {31'd0, hready2}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, hready2}, 32'd1);
        check("abort_data",  hrdata2, 32'h0);
        check("abort_resp",  {31'd0, hresp2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; hwdata = 32'h0;
        xfer(2, 1'b0, 32'h10, 3'b010, 32'h0, rd, low, err);
        check("abort_rd", rd, 32'h0);
        check("abort_rd_low", 32'(low), 32'd2);
        xfer(2, 1'b0, 32'hC, 3'b010, 32'h0, rd, low, err);
        check("rst_clears_ws", rd, 32'h0);
        xfer(0, 1'b0, 32'h4, 3'b010, 32'h0, rd, low, err);
        check("rst_clears_nows", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
